// File: rtl/deserializer.sv
// Serial-to-parallel receiver. It samples one bit per clock while srl_vld is
// high and assembles WIDTH-bit frames. Each completed word goes to a one-deep
// valid/ready output register. It also reports truncated frames (frame_err)
// and completed words that are dropped because the output was still full
// (overrun).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no frame in progress; the next srl_vld=1 cycle is bit 0
//   SHIFT | bits 1..WIDTH-1 of the current frame are still expected
module deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srl_in,
  input  logic             srl_vld,
  output logic             srl_busy,
  output logic [WIDTH-1:0] pll_out,
  output logic             pll_vld,
  input  logic             pll_rdy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    SHIFT = 1'b1;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic [CW-1:0]    bit_idx;
  logic             complete;
  logic             abort;
  logic             out_free;

  // Frame assembly: steer the incoming bit into its word position and track the frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    complete = 1'b0;
    abort    = 1'b0;
    bit_idx  = LSB_FIRST ? cnt_q : (LAST - cnt_q);
    if (state_q == IDLE) begin
      if (srl_vld) begin
        // Start from a clean word so that no bits from an older frame survive.
        shift_d          = '0;
        shift_d[bit_idx] = srl_in;
        cnt_d            = CW'(1);
        state_d          = SHIFT;
      end
    end else begin
      if (srl_vld) begin
        shift_d[bit_idx] = srl_in;
        if (cnt_q == LAST) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        abort   = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  // Output register handshake, frame error pulse and sticky overrun.
  always_comb begin
    out_free = !vld_q || pll_rdy;
    out_d    = out_q;
    vld_d    = vld_q;
    ovr_d    = ovr_q;
    ferr_d   = abort;
    if (complete && out_free) begin
      // This also covers a word accepted in the same cycle, so there is no bubble.
      out_d = shift_d;
      vld_d = 1'b1;
    end else if (vld_q && pll_rdy) begin
      vld_d = 1'b0;
    end
    // If an overrun and ovr_clr arrive together, the new overrun takes priority.
    if (complete && !out_free) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // State and data registers; asynchronous reset discards any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign srl_busy  = (state_q == SHIFT);
  assign pll_out   = out_q;
  assign pll_vld   = vld_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer. It runs an LSB-first and an MSB-first
// instance side by side on the same serial stream.
module tb_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       srl_in = 1'b0;
  logic       srl_vld = 1'b0;
  logic       pll_rdy = 1'b0;
  logic       ovr_clr = 1'b0;

  logic       busy_l, vld_l, ferr_l, ovr_l;
  logic [3:0] out_l;
  logic       busy_m, vld_m, ferr_m, ovr_m;
  logic [3:0] out_m;

  int errors = 0;
  int checks = 0;

  logic [3:0] lb [32] = '{4'h3, 4'hA, 4'hF, 4'h0, 4'h7, 4'hC, 4'h1, 4'h8,
                          4'hE, 4'h5, 4'h9, 4'h2, 4'hB, 4'h4, 4'h6, 4'hD,
                          4'hD, 4'h6, 4'h4, 4'hB, 4'h2, 4'h9, 4'h5, 4'hE,
                          4'h8, 4'h1, 4'hC, 4'h7, 4'h0, 4'hF, 4'hA, 4'h3};

  deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .srl_in(srl_in), .srl_vld(srl_vld),
    .srl_busy(busy_l), .pll_out(out_l), .pll_vld(vld_l), .pll_rdy(pll_rdy),
    .frame_err(ferr_l), .overrun(ovr_l), .ovr_clr(ovr_clr));

  deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .srl_in(srl_in), .srl_vld(srl_vld),
    .srl_busy(busy_m), .pll_out(out_m), .pll_vld(vld_m), .pll_rdy(pll_rdy),
    .frame_err(ferr_m), .overrun(ovr_m), .ovr_clr(ovr_clr));

  always #5 clk = ~clk;

  function automatic logic [3:0] rev4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // Present one serial cycle, then return 1 time unit after the sampling edge.
  task automatic drive_bit(input logic v, input logic b);
    srl_vld = v;
    srl_in  = b;
    @(posedge clk);
    #1;
  endtask

  // Send the bits of w one after another, bit 0 first. srl_vld stays high afterwards.
  task automatic send_frame(input logic [3:0] w);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_l !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_l); end
    checks++; if ({vld_l, ferr_l, ovr_l, out_l} !== 7'd0) begin errors++; $display("FAIL reset_outs got=%b exp=0", {vld_l, ferr_l, ovr_l, out_l}); end
    rst = 1'b1;
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    checks++; if ({busy_l, vld_l, ferr_l, ovr_l, out_l} !== 8'd0) begin errors++; $display("FAIL idle_after_release got=%b exp=0", {busy_l, vld_l, ferr_l, ovr_l, out_l}); end
  endtask

  task automatic test_basic_frame();
    logic [3:0] bits;
    bits = 4'b1101;
    pll_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_l !== (i != 0)) begin errors++; $display("FAIL basic_busy bit=%0d got=%b exp=%b", i, busy_l, (i != 0)); end
      checks++;
      if (vld_l !== 1'b0) begin errors++; $display("FAIL basic_early_vld bit=%0d got=%b exp=0", i, vld_l); end
      drive_bit(1'b1, bits[i]);
    end
    srl_vld = 1'b0;
    checks++; if (vld_l !== 1'b1) begin errors++; $display("FAIL basic_vld got=%b exp=1", vld_l); end
    checks++; if (busy_l !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy_l); end
    checks++; if (out_l !== 4'hD) begin errors++; $display("FAIL basic_lsb_out got=%h exp=d", out_l); end
    checks++; if (out_m !== 4'hB) begin errors++; $display("FAIL basic_msb_out got=%h exp=b", out_m); end
    drive_bit(1'b0, 1'b0);
    checks++; if (vld_l !== 1'b0) begin errors++; $display("FAIL basic_vld_clear got=%b exp=0", vld_l); end
  endtask

  task automatic test_loopback();
    pll_rdy = 1'b1;
    for (int n = 0; n < 32; n++) begin
      send_frame(lb[n]);
      checks++;
      if (vld_l !== 1'b1 || out_l !== lb[n]) begin errors++; $display("FAIL loop_lsb n=%0d got=%b/%h exp=1/%h", n, vld_l, out_l, lb[n]); end
      checks++;
      if (out_m !== rev4(lb[n])) begin errors++; $display("FAIL loop_msb n=%0d got=%h exp=%h", n, out_m, rev4(lb[n])); end
      checks++;
      if (ferr_l !== 1'b0 || ovr_l !== 1'b0) begin errors++; $display("FAIL loop_flags n=%0d got=%b%b exp=00", n, ferr_l, ovr_l); end
      drive_bit(1'b0, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    pll_rdy = 1'b0;
    send_frame(4'h3);
    checks++; if (vld_l !== 1'b1 || out_l !== 4'h3 || ovr_l !== 1'b0) begin errors++; $display("FAIL bp_first got=%b/%h/%b exp=1/3/0", vld_l, out_l, ovr_l); end
    send_frame(4'h9);
    srl_vld = 1'b0;
    checks++; if (vld_l !== 1'b1 || out_l !== 4'h3) begin errors++; $display("FAIL bp_hold got=%b/%h exp=1/3", vld_l, out_l); end
    checks++; if (ovr_l !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%b exp=1", ovr_l); end
    checks++; if (ferr_l !== 1'b0) begin errors++; $display("FAIL bp_no_ferr got=%b exp=0", ferr_l); end
    drive_bit(1'b0, 1'b0);
    checks++; if (vld_l !== 1'b1) begin errors++; $display("FAIL bp_stall_vld got=%b exp=1", vld_l); end
    pll_rdy = 1'b1;
    drive_bit(1'b0, 1'b0);
    pll_rdy = 1'b0;
    checks++; if (vld_l !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b exp=0", vld_l); end
    checks++; if (ovr_l !== 1'b1) begin errors++; $display("FAIL bp_sticky got=%b exp=1", ovr_l); end
    ovr_clr = 1'b1;
    drive_bit(1'b0, 1'b0);
    ovr_clr = 1'b0;
    checks++; if (ovr_l !== 1'b0) begin errors++; $display("FAIL bp_clear got=%b exp=0", ovr_l); end
    // A new overrun in the same cycle as ovr_clr leaves overrun set.
    send_frame(4'hA);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    ovr_clr = 1'b1;
    drive_bit(1'b1, 1'b1);
    ovr_clr = 1'b0;
    srl_vld = 1'b0;
    checks++; if (ovr_l !== 1'b1 || out_l !== 4'hA) begin errors++; $display("FAIL set_wins got=%b/%h exp=1/a", ovr_l, out_l); end
    ovr_clr = 1'b1;
    pll_rdy = 1'b1;
    drive_bit(1'b0, 1'b0);
    ovr_clr = 1'b0;
    checks++; if (ovr_l !== 1'b0 || vld_l !== 1'b0) begin errors++; $display("FAIL set_wins_clear got=%b/%b exp=0/0", ovr_l, vld_l); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] b;
    b = 4'h5;
    pll_rdy = 1'b0;
    send_frame(4'hA);
    checks++; if (vld_l !== 1'b1 || out_l !== 4'hA) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/a", vld_l, out_l); end
    // The consumer stalls for the first three bits of the next frame, then
    // accepts in the same cycle that the second word completes.
    for (int i = 0; i < 4; i++) begin
      pll_rdy = (i == 3);
      drive_bit(1'b1, b[i]);
      checks++;
      if (vld_l !== 1'b1) begin errors++; $display("FAIL b2b_vld bit=%0d got=%b exp=1", i, vld_l); end
    end
    srl_vld = 1'b0;
    pll_rdy = 1'b1;
    checks++; if (out_l !== 4'h5 || out_m !== 4'hA) begin errors++; $display("FAIL b2b_second got=%h/%h exp=5/a", out_l, out_m); end
    checks++; if (ovr_l !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr got=%b exp=0", ovr_l); end
    drive_bit(1'b0, 1'b0);
    checks++; if (vld_l !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", vld_l); end
  endtask

  task automatic test_truncation();
    pll_rdy = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    checks++; if (busy_l !== 1'b1 || ferr_l !== 1'b0) begin errors++; $display("FAIL trunc_mid got=%b%b exp=10", busy_l, ferr_l); end
    drive_bit(1'b0, 1'b1);
    checks++; if (ferr_l !== 1'b1 || busy_l !== 1'b0) begin errors++; $display("FAIL trunc_pulse got=%b%b exp=10", ferr_l, busy_l); end
    checks++; if (vld_l !== 1'b0 || ovr_l !== 1'b0) begin errors++; $display("FAIL trunc_no_word got=%b%b exp=00", vld_l, ovr_l); end
    drive_bit(1'b0, 1'b0);
    checks++; if (ferr_l !== 1'b0) begin errors++; $display("FAIL trunc_one_cycle got=%b exp=0", ferr_l); end
    send_frame(4'h6);
    checks++; if (vld_l !== 1'b1 || out_l !== 4'h6) begin errors++; $display("FAIL trunc_recover got=%b/%h exp=1/6", vld_l, out_l); end
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    checks++; if (busy_l !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got=%b exp=1", busy_l); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({busy_l, vld_l, ferr_l, ovr_l, out_l} !== 8'd0) begin errors++; $display("FAIL rst_async got=%b exp=0", {busy_l, vld_l, ferr_l, ovr_l, out_l}); end
    srl_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_bit(1'b0, 1'b0);
    checks++; if ({busy_l, vld_l, ferr_l, ovr_l} !== 4'd0) begin errors++; $display("FAIL rst_no_ferr got=%b exp=0", {busy_l, vld_l, ferr_l, ovr_l}); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_loopback();
    test_backpressure();
    test_back_to_back();
    test_truncation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
